// File: rtl/alu_sub_arbiter_pkg.sv
// Shared types and constants for the Y86 ALU subtract/compare arbiter.
// The flag triple maps onto the condition-code register fields.
package y86_alu_pkg;

    localparam int WORD_W = 64;

    localparam logic REQ_EXE  = 1'b0;
    localparam logic REQ_ADDR = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } flags_t;

    // Overflow is the carry out of the sign bit XOR the carry into it.
    function automatic flags_t calc_flags(input logic [WORD_W-1:0] diff,
                                          input logic c63,
                                          input logic c62);
        flags_t f;
        f.zf = (diff == '0);
        f.sf = diff[WORD_W-1];
        f.of = c63 ^ c62;
        return f;
    endfunction

endpackage

// File: rtl/alu_sub_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the arbiter and
// the condition-code consumer.
interface alu_sub_arbiter_if;
    import y86_alu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [WORD_W-1:0] req0_a;
    logic [WORD_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [WORD_W-1:0] req1_a;
    logic [WORD_W-1:0] req1_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WORD_W-1:0] rsp_diff;
    logic              rsp_zf;
    logic              rsp_sf;
    logic              rsp_of;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_diff, rsp_zf, rsp_sf, rsp_of
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_diff, rsp_zf, rsp_sf, rsp_of
    );

endinterface

// File: rtl/alu_sub_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin against last_grant, or fixed priority to
// requester 0 when rr_en is low.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_en,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);
    always_comb begin
        any   = |valid;
        grant = 1'b0;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = rr_en ? ~last_grant : 1'b0;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_subtractor_64.sv
// Shared 64-bit subtractor: a + ~b + 1, exposing carries out of bits 63 and 62.
module alu_subtractor_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] diff,
    output logic        carry_out,
    output logic        carry_62
);
    logic [63:0] b_inv;
    logic [64:0] sum;

    // The carry into bit 63 falls out of the sum bit and its two operand bits.
    always_comb begin
        b_inv     = ~b;
        sum       = {1'b0, a} + {1'b0, b_inv} + 65'd1;
        diff      = sum[63:0];
        carry_out = sum[64];
        carry_62  = a[63] ^ b_inv[63] ^ sum[63];
    end

endmodule

// File: rtl/alu_sub_arbiter.sv
// Shares one 64-bit subtractor between the execute compare path and the
// address/decrement path; the result and Y86 flags sit in a one-entry register.
module alu_sub_arbiter #(
    parameter bit RR_EN  = 1'b1,
    parameter int WORD_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sub_arbiter_if.slave bus
);
    import y86_alu_pkg::*;

    if (WORD_W != 64) begin : g_width_check
        $error("alu_sub_arbiter: WORD_W must be 64 to match alu_subtractor_64");
    end

    rsp_state_t        state;
    rsp_state_t        state_next;
    logic              grant;
    logic              any;
    logic              last_grant;
    logic              can_accept;
    logic              xfer;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic [WORD_W-1:0] sub_diff;
    logic              sub_c63;
    logic              sub_c62;
    flags_t            sub_flags;
    flags_t            flags_q;
    logic [WORD_W-1:0] diff_q;
    logic              id_q;

    rr_arb2 u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .rr_en      (RR_EN),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (any)
    );

    alu_subtractor_64 u_sub (
        .a         (op_a),
        .b         (op_b),
        .diff      (sub_diff),
        .carry_out (sub_c63),
        .carry_62  (sub_c62)
    );

    // Readies come only from valids and the response handshake, never from operands.
    always_comb begin
        can_accept     = (state == EMPTY) || bus.rsp_ready;
        bus.req0_ready = any && (grant == REQ_EXE) && can_accept;
        bus.req1_ready = any && (grant == REQ_ADDR) && can_accept;
        xfer           = any && can_accept;
        op_a           = (grant == REQ_ADDR) ? bus.req1_a : bus.req0_a;
        op_b           = (grant == REQ_ADDR) ? bus.req1_b : bus.req0_b;
        sub_flags      = calc_flags(sub_diff, sub_c63, sub_c62);
        state_next     = state;
        case (state)
            EMPTY:   if (xfer) state_next = FULL;
            FULL:    if (!xfer && bus.rsp_ready) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A draining entry may be overwritten in the same cycle for back-to-back results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q     <= '0;
            flags_q    <= '0;
            id_q       <= REQ_EXE;
            last_grant <= REQ_ADDR;
        end else if (xfer) begin
            diff_q     <= sub_diff;
            flags_q    <= sub_flags;
            id_q       <= grant;
            last_grant <= grant;
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_diff  = diff_q;
    assign bus.rsp_zf    = flags_q.zf;
    assign bus.rsp_sf    = flags_q.sf;
    assign bus.rsp_of    = flags_q.of;

endmodule

// File: tb/tb_alu_sub_arbiter.sv
// Scoreboard bench for alu_sub_arbiter: the driver queues expected results on
// each accepted request and a monitor pops them as responses are consumed.
module tb_alu_sub_arbiter;

    typedef struct packed {
        logic        id;
        logic [63:0] diff;
        logic        zf;
        logic        sf;
        logic        of;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_sub_arbiter_if bus ();
    alu_sub_arbiter_if bus_fp ();

    alu_sub_arbiter #(.RR_EN(1'b1), .WORD_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_sub_arbiter #(.RR_EN(1'b0), .WORD_W(64)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic id, input logic [63:0] d,
                                input logic zf, input logic sf, input logic of);
        exp_t e;
        e.id   = id;
        e.diff = d;
        e.zf   = zf;
        e.sf   = sf;
        e.of   = of;
        return e;
    endfunction

    // Reference model: overflow when operand signs differ and the result sign flips.
    function automatic exp_t ref_model(input logic id, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] d;
        d = a - b;
        return mk(id, d, d == 64'd0, d[63], (a[63] != b[63]) && (d[63] != a[63]));
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; readies are checked just before the next rising edge.
    task automatic applyStimulus(input logic v0, input logic [63:0] a0, input logic [63:0] b0,
                                 input logic v1, input logic [63:0] a1, input logic [63:0] b1,
                                 input logic rdy, input logic er0, input logic er1,
                                 input exp_t e);
        @(negedge clk);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.rsp_ready  = rdy;
        #4;
        checkOutput("req0_ready", {63'd0, bus.req0_ready}, {63'd0, er0});
        checkOutput("req1_ready", {63'd0, bus.req1_ready}, {63'd0, er1});
        if (er0 || er1) sb.push_back(e);
    endtask

    always begin
        @(negedge clk);
        #4;
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rsp_unexpected: got diff %h id %0d expected no response",
                         bus.rsp_diff, bus.rsp_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_id",   {63'd0, bus.rsp_id}, {63'd0, e.id});
                checkOutput("rsp_diff", bus.rsp_diff, e.diff);
                checkOutput("rsp_zf",   {63'd0, bus.rsp_zf}, {63'd0, e.zf});
                checkOutput("rsp_sf",   {63'd0, bus.rsp_sf}, {63'd0, e.sf});
                checkOutput("rsp_of",   {63'd0, bus.rsp_of}, {63'd0, e.of});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t idle;
        logic [63:0] ra;
        logic [63:0] rb;
        idle = '0;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;  bus.req0_a = '0;  bus.req0_b = '0;
        bus.req1_valid = 1'b0;  bus.req1_a = '0;  bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        bus_fp.req0_valid = 1'b0;  bus_fp.req0_a = '0;  bus_fp.req0_b = '0;
        bus_fp.req1_valid = 1'b0;  bus_fp.req1_a = '0;  bus_fp.req1_b = '0;
        bus_fp.rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #4;
        checkOutput("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        checkOutput("reset_rsp_id",    {63'd0, bus.rsp_id},    64'd0);
        checkOutput("reset_rsp_diff",  bus.rsp_diff,           64'd0);
        checkOutput("reset_rsp_flags", {61'd0, bus.rsp_zf, bus.rsp_sf, bus.rsp_of}, 64'd0);

        // Single requests on each side, including signed overflow.
        applyStimulus(1, 64'd5, 64'd3, 0, 0, 0, 1, 1, 0, mk(0, 64'd2, 0, 0, 0));
        applyStimulus(0, 0, 0, 1, 64'h8000_0000_0000_0000, 64'd1, 1, 0, 1,
                      mk(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1));

        // Continuous contention alternates grants.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                applyStimulus(1, 64'd10, 64'd3, 1, 64'd3, 64'd10, 1, 1, 0, mk(0, 64'd7, 0, 0, 0));
            else
                applyStimulus(1, 64'd10, 64'd3, 1, 64'd3, 64'd10, 1, 0, 1,
                              mk(1, 64'hFFFF_FFFF_FFFF_FFF9, 0, 1, 0));
        end

        // Stall with a full register, then drain and refill in the same cycle.
        applyStimulus(1, 64'h1234, 64'h1234, 0, 0, 0, 1, 1, 0, mk(0, 64'd0, 1, 0, 0));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 64'd9, 64'd4, 0, 0, 0, idle);
            checkOutput("stall_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
            checkOutput("stall_rsp_diff",  bus.rsp_diff, 64'd0);
            checkOutput("stall_rsp_zf",    {63'd0, bus.rsp_zf}, 64'd1);
            checkOutput("stall_rsp_id",    {63'd0, bus.rsp_id}, 64'd0);
        end
        applyStimulus(0, 0, 0, 1, 64'd9, 64'd4, 1, 0, 1, mk(1, 64'd5, 0, 0, 0));
        applyStimulus(1, 64'd0, 64'd1, 0, 0, 0, 1, 1, 0, mk(0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0));
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, idle);

        // Reset while a result is held discards it and restores req0 priority.
        applyStimulus(1, 64'd100, 64'd1, 0, 0, 0, 1, 1, 0, mk(0, 64'd99, 0, 0, 0));
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        checkOutput("async_reset_rsp_diff",  bus.rsp_diff, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 64'd7, 64'd7, 1, 64'd1, 64'd2, 1, 1, 0, mk(0, 64'd0, 1, 0, 0));
        applyStimulus(1, 64'd7, 64'd7, 1, 64'd1, 64'd2, 1, 0, 1,
                      mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0));

        // Random signed pairs against the reference model.
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 0) begin ra = 64'h7FFF_FFFF_FFFF_FFFF; rb = 64'hFFFF_FFFF_FFFF_FFFF; end
            if (i == 1) begin ra = 64'h8000_0000_0000_0000; rb = 64'h8000_0000_0000_0000; end
            applyStimulus(1, ra, rb, 0, 0, 0, 1, 1, 0, ref_model(0, ra, rb));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, idle);
        checkOutput("scoreboard_drain", 64'(sb.size()), 64'd0);

        // Fixed-priority instance: req1 starves while req0 stays valid.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_fp.req0_valid = 1'b1;  bus_fp.req0_a = 64'd20;  bus_fp.req0_b = 64'd8;
            bus_fp.req1_valid = 1'b1;  bus_fp.req1_a = 64'd1;   bus_fp.req1_b = 64'd1;
            bus_fp.rsp_ready  = 1'b1;
            #4;
            checkOutput("fp_req0_ready", {63'd0, bus_fp.req0_ready}, 64'd1);
            checkOutput("fp_req1_ready", {63'd0, bus_fp.req1_ready}, 64'd0);
            if (i > 0) begin
                checkOutput("fp_rsp_valid", {63'd0, bus_fp.rsp_valid}, 64'd1);
                checkOutput("fp_rsp_id",    {63'd0, bus_fp.rsp_id},    64'd0);
                checkOutput("fp_rsp_diff",  bus_fp.rsp_diff,           64'd12);
            end
        end
        @(negedge clk);
        bus_fp.req0_valid = 1'b0;
        bus_fp.req1_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sub_arbiter.md
Name: alu_sub_arbiter

Overview:
- Shares one 64-bit `alu_subtractor_64` instance between two requesters, e.g. the execute-stage compare path and the address/decrement path.
- Arbitrates between the requesters and registers the difference together with Y86 condition flags (ZF, SF, OF).
- Presents the result on a valid/ready response channel, tagged with the id of the winning requester.
- Sits in the ALU between the decode/execute control and the condition-code register.

Parameters:
- RR_EN, 1: 1 = round-robin arbitration between req0 and req1; 0 = fixed priority, req0 always wins.
- WORD_W, 64: operand/result width. Fixed at 64 to match the subtractor; any other value is illegal and is flagged by an elaboration check.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 pair accepted this cycle.
- req0_a  input  64  minuend, requester 0.
- req0_b  input  64  subtrahend, requester 0.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_ready  output  1  requester 1 pair accepted this cycle.
- req1_a  input  64  minuend, requester 1.
- req1_b  input  64  subtrahend, requester 1.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_id  output  1  requester that owns the result (0/1).
- rsp_diff  output  64  registered a − b, two's complement, modulo 2^64.
- rsp_zf  output  1  rsp_diff == 0.
- rsp_sf  output  1  rsp_diff[63].
- rsp_of  output  1  signed overflow: carry-out of bit 63 XOR carry-out of bit 62.

Behaviour:
- Reset (async, rst_n low):
  - rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_zf=0, rsp_sf=0, rsp_of=0.
  - last_grant=1, so req0 wins the first contention.
  - Any result in flight is discarded, not delivered.
  - Deassertion takes effect on the next clk edge.
- States (result register is single-entry):
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = !rsp_valid || rsp_ready. A FULL register draining this cycle may be refilled in the same cycle, giving 1 result/cycle throughput.
- Grant (combinational):
  - Only one valid → that requester.
  - Both valid, RR_EN=1 → the requester that is not last_grant.
  - Both valid, RR_EN=0 → req0.
- reqX_ready = grant==X && can_accept. Never both high.
- reqX_ready depends combinationally on req0_valid, req1_valid, rsp_valid and rsp_ready. It is free of any path through its own operands.
- Transfer occurs when reqX_valid && reqX_ready.
- On a transfer, at the next edge:
  - The muxed a/b pass through the subtractor.
  - rsp_diff, the flags and rsp_id=X are loaded; rsp_valid=1.
  - last_grant=X.
  - Latency is exactly 1 cycle from acceptance to rsp_valid.
- rsp_valid && rsp_ready with no new transfer → EMPTY next edge. rsp_* outputs hold their last values but are don't-care.
- rsp_valid && !rsp_ready → all rsp_* outputs stable, no grant issued, both readys low.
- last_grant updates only on an actual transfer, not on a mere request.
- A requester must hold valid and operands until ready. Withdrawal before ready is permitted and leaves no side effect.
- Flag rules:
  - ZF is computed on the 64-bit difference.
  - SF = MSB.
  - OF per the carry rule above; no carry/borrow flag is exported.
  - Wrap-around is silent: e.g. 0 − 1 = 0xFFFF_FFFF_FFFF_FFFF, SF=1, OF=0.
- No X propagation: with no transfer the subtractor inputs are don't-care, and the result register must not load.

Decomposition:
- Package y86_alu_pkg:
  - WORD_W=64.
  - Requester id constants REQ_EXE=1'b0, REQ_ADDR=1'b1.
  - A struct/typedef for the flag triple {zf, sf, of}.
- Sub-module rr_arb2: a 2-way arbiter with inputs valid[1:0], rr_en, last_grant, and outputs grant and any.
- The subtractor is instantiated directly; it is not re-implemented.

Test Plan:
1. After reset, req0 a=5 b=3, rsp_ready=1.
   - Required: req0_ready=1 in the same cycle.
   - Next cycle: rsp_valid=1, rsp_diff=2, zf=0, sf=0, of=0, rsp_id=0.
2. req1 a=0x8000_0000_0000_0000 b=1.
   - Required: rsp_diff=0x7FFF_FFFF_FFFF_FFFF, of=1, sf=0, zf=0, rsp_id=1.
3. Both valid every cycle with RR_EN=1, rsp_ready=1.
   - Required: grants alternate 0,1,0,1, with one result per cycle.
   - With RR_EN=0: always 0; req1 starves while req0 stays valid.
4. Full register with rsp_ready=0 for 4 cycles, a=b=0x1234.
   - Required: outputs stable with zf=1, both readys low.
   - Then rsp_ready=1 with req1 pending: new result loads the following cycle, no bubble.
5. Assert rst_n low mid-transfer while rsp_valid=1.
   - Required: rsp_valid=0 immediately (async).
   - After release, the first contention is granted to req0.
6. Operands a=0 b=1.
   - Required: rsp_diff=0xFFFF_FFFF_FFFF_FFFF, sf=1, of=0.
   - Random signed pairs must be checked against a reference model: diff = a−b mod 2^64, flags as defined above.
